// File: rtl/fft_pingpong_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pingpong_buf
//  Description : Two-bank (ping-pong) complex sample buffer between the
//                ADC/windowing front end and the FFT core. One bank fills
//                from the input stream while the other drains to the FFT,
//                so complete frames stream out without gaps. Real and
//                imaginary lanes are stored side by side in one RAM word.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W    width of each re/im lane
//    ADDR_W    log2 of the frame length (N = 2**ADDR_W samples per bank)
//  Ports
//    clk       single clock for all logic and both RAM ports
//    rst       synchronous, active-high reset
//    in_valid  / in_ready  / in_re  / in_im   input sample handshake + data
//    out_valid / out_ready / out_re / out_im  output sample handshake + data
//    out_idx   RAM address the current output sample was read from
//    out_last  current output is position N-1 of its frame (output order)
//    overflow  sticky: a sample was offered while in_ready was low
//  Configuration
//    FFT_BUF_BITREV_EN  when defined, each bank is read in bit-reversed
//                       address order (DIT FFT input order); otherwise the
//                       read order is natural. Handshake, latency and
//                       out_last behaviour do not change.
// ============================================================================
module fft_pingpong_buf #(
    parameter int DATA_W = 23,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              overflow
);

    // Both banks live in one array; the bank select is the address MSB.
    localparam int                c_DEPTH = 2 ** (ADDR_W + 1);
    localparam logic [ADDR_W-1:0] c_LAST  = '1;           // N-1
    localparam logic [ADDR_W-1:0] c_ONE   = ADDR_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2*DATA_W-1:0] r_mem [c_DEPTH];

    logic [1:0]          r_full;        // per-bank "frame complete" flag
    logic                r_wb;          // bank currently being written
    logic                r_rb;          // bank currently being read
    logic [ADDR_W-1:0]   r_wcnt;
    logic [ADDR_W-1:0]   r_rcnt;

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_re;
    logic [DATA_W-1:0]   r_out_im;
    logic [ADDR_W-1:0]   r_out_idx;
    logic                r_out_last;
    logic                r_overflow;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                w_in_ready;
    logic                w_wr;
    logic                w_re;
    logic [ADDR_W-1:0]   w_raddr;
    logic [2*DATA_W-1:0] w_rd_word;
    logic [1:0]          w_full_nxt;

    assign w_in_ready = ~r_full[r_wb];
    assign w_wr       = in_valid & w_in_ready;

    // Issue a read whenever the read bank holds a complete frame and the
    // output register is empty or being emptied this cycle.
    assign w_re       = r_full[r_rb] & (~r_out_valid | out_ready);

`ifdef FFT_BUF_BITREV_EN
    // Bit-reversed read order: raddr[i] = rcnt[ADDR_W-1-i].
    generate
        for (genvar i = 0; i < ADDR_W; i++) begin : g_bitrev
            assign w_raddr[i] = r_rcnt[ADDR_W-1-i];
        end
    endgenerate
`else
    assign w_raddr = r_rcnt;
`endif

    assign w_rd_word = r_mem[{r_rb, w_raddr}];

    // The writer only ever sets an empty bank and the reader only ever
    // clears a full one, so the set and clear below never collide even
    // when both happen in the same cycle.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr && (r_wcnt == c_LAST)) begin
            w_full_nxt[r_wb] = 1'b1;
        end
        if (w_re && (r_rcnt == c_LAST)) begin
            w_full_nxt[r_rb] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sample RAM write port (contents deliberately not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[{r_wb, r_wcnt}] <= {in_re, in_im};
        end
    end

    // ------------------------------------------------------------------
    // Control state and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full      <= 2'b00;
            r_wb        <= 1'b0;
            r_rb        <= 1'b0;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_full <= w_full_nxt;

            // Offered-but-refused samples are dropped; remember it.
            if (in_valid && !w_in_ready) begin
                r_overflow <= 1'b1;
            end

            // Write side: counter wraps to 0 naturally after N-1.
            if (w_wr) begin
                r_wcnt <= r_wcnt + c_ONE;
                if (r_wcnt == c_LAST) begin
                    r_wb <= ~r_wb;
                end
            end

            // Read side: the bank is released as soon as its last read is
            // issued, since that sample is then already in the output regs.
            if (w_re) begin
                r_out_valid <= 1'b1;
                r_out_re    <= w_rd_word[2*DATA_W-1:DATA_W];
                r_out_im    <= w_rd_word[DATA_W-1:0];
                r_out_idx   <= w_raddr;
                r_out_last  <= (r_rcnt == c_LAST);
                r_rcnt      <= r_rcnt + c_ONE;
                if (r_rcnt == c_LAST) begin
                    r_rb <= ~r_rb;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fft_pingpong_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_pingpong_buf
//  Description : Self-checking bench for fft_pingpong_buf (DATA_W=23,
//                ADDR_W=3). A frame-level reference model turns accepted
//                input samples into the expected output sequence; a vector
//                table covers the basic frame timing, and directed plus
//                random sequences cover overflow, back-to-back frames,
//                output stalls and mid-frame reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_pingpong_buf;

    localparam int DW = 23;
    localparam int AW = 3;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic [AW-1:0] out_idx;
    logic          out_last;
    logic          overflow;

    fft_pingpong_buf #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Bookkeeping and reference model
    // ------------------------------------------------------------------
    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    int first_out = 0;
    int last_out = 0;

    logic [2*DW-1:0]        cur   [$];   // samples of the frame being filled
    logic [2*DW+AW:0]       exp_q [$];   // {re, im, idx, last} in output order
    bit                     hold_pend = 1'b0;
    logic [2*DW+AW+1:0]     hold_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Output position j of a frame is read from this address.
    function automatic logic [AW-1:0] ref_addr(input int j);
        int r;
`ifdef FFT_BUF_BITREV_EN
        r = 0;
        for (int i = 0; i < AW; i++)
            if (((j >> i) & 1) == 1) r = r | (1 << (AW - 1 - i));
`else
        r = j;
`endif
        return r[AW-1:0];
    endfunction

    task automatic model_push(input logic [DW-1:0] re, input logic [DW-1:0] im);
        logic [AW-1:0] a;
        logic          l;
        cur.push_back({re, im});
        if (cur.size() == N) begin
            for (int j = 0; j < N; j++) begin
                a = ref_addr(j);
                l = (j == N - 1);
                exp_q.push_back({cur[a], a, l});
            end
            cur.delete();
        end
    endtask

    // Called at every negedge: records handshakes and checks outputs.
    task automatic observe();
        logic [2*DW+AW:0] e;
        cyc++;
        if (hold_pend)
            chk("hold_stable", {out_valid, out_re, out_im, out_idx, out_last}, hold_val);
        hold_pend = out_valid && !out_ready;
        hold_val  = {out_valid, out_re, out_im, out_idx, out_last};
        if (in_valid && in_ready) begin
            acc_cnt++;
            model_push(in_re, in_im);
        end
        if (out_valid && out_ready) begin
            out_cnt++;
            if (out_cnt == 1) first_out = cyc;
            last_out = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {out_re, out_im, out_idx, out_last}, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", {out_re, out_im, out_idx, out_last}, e);
            end
        end
    endtask

    // One clock cycle: drive after the edge, observe at the negedge.
    // With gate=1 in_valid is only raised while in_ready is high.
    task automatic tick(input bit want_v, input bit gate, input logic [DW-1:0] re,
                        input logic [DW-1:0] im, input bit ordy);
        @(posedge clk);
        #1;
        in_valid  = want_v && (!gate || in_ready);
        in_re     = re;
        in_im     = im;
        out_ready = ordy;
        @(negedge clk);
        observe();
    endtask

    task automatic check_reset_state();
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_re",    64'(out_re),    64'd0);
        chk("rst_out_im",    64'(out_im),    64'd0);
        chk("rst_out_idx",   64'(out_idx),   64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_overflow",  64'(overflow),  64'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state();
        cur.delete();
        exp_q.delete();
        hold_pend = 1'b0;
    endtask

    task automatic drain(input bit tog);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(1'b0, 1'b1, '0, '0, tog ? 1'(n) : 1'b1);
            n++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'd0);
        repeat (3) tick(1'b0, 1'b1, '0, '0, 1'b1);
    endtask

    // ------------------------------------------------------------------
    // Vector table for the basic one-frame sequence
    // ------------------------------------------------------------------
    typedef struct {
        bit            v;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        bit            ordy;
        bit            e_ird;
        bit            e_ov;
        logic [DW-1:0] e_re;
        logic [DW-1:0] e_im;
        logic [AW-1:0] e_idx;
        bit            e_last;
    } vec_t;

    vec_t tbl [18];
    int   base;
    int   k;
    logic [AW-1:0] o;

    initial begin
        // Rows 0..7 write re=k, im=100+k. The 8th accept is the edge that
        // ends row 7; the read issues at the next edge, so data appears
        // from row 9 to row 16 and out_valid is low again in row 17.
        for (int r = 0; r < 18; r++) begin
            tbl[r] = '{v: 1'b0, re: '0, im: '0, ordy: 1'b1, e_ird: 1'b1, e_ov: 1'b0,
                       e_re: '0, e_im: '0, e_idx: '0, e_last: 1'b0};
            if (r < 8) begin
                tbl[r].v  = 1'b1;
                tbl[r].re = DW'(r);
                tbl[r].im = DW'(100 + r);
            end
            if (r >= 9 && r <= 16) begin
                o = ref_addr(r - 9);
                tbl[r].e_ov   = 1'b1;
                tbl[r].e_re   = DW'(o);
                tbl[r].e_im   = DW'(100) + DW'(o);
                tbl[r].e_idx  = o;
                tbl[r].e_last = (r == 16);
            end
        end

        apply_reset();

        // --- table-driven single frame ---------------------------------
        for (int r = 0; r < 18; r++) begin
            tick(tbl[r].v, 1'b0, tbl[r].re, tbl[r].im, tbl[r].ordy);
            chk("tbl_in_ready",  64'(in_ready),  64'(tbl[r].e_ird));
            chk("tbl_out_valid", 64'(out_valid), 64'(tbl[r].e_ov));
            if (tbl[r].e_ov)
                chk("tbl_out", {out_re, out_im, out_idx, out_last},
                    {tbl[r].e_re, tbl[r].e_im, tbl[r].e_idx, tbl[r].e_last});
        end
        chk("tbl_drained", 64'(exp_q.size()), 64'd0);

        // --- overflow: fill both banks with the output stalled ---------
        base = acc_cnt;
        k = 0;
        while (acc_cnt - base < 2 * N && k < 60) begin
            tick(1'b1, 1'b1, DW'(200 + acc_cnt - base), DW'(300 + acc_cnt - base), 1'b0);
            k++;
        end
        tick(1'b0, 1'b1, '0, '0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_no_ovf",   64'(overflow), 64'd0);
        tick(1'b1, 1'b0, DW'(999), DW'(999), 1'b0);       // 17th offer, refused
        chk("ovf_offer_refused", 64'(in_ready), 64'd0);
        repeat (3) begin
            tick(1'b0, 1'b1, '0, '0, 1'b0);
            chk("ovf_set", 64'(overflow), 64'd1);
        end
        chk("ovf_accepts", 64'(acc_cnt - base), 64'd16);
        out_cnt = 0;
        drain(1'b0);
        chk("ovf_out_count", 64'(out_cnt), 64'd16);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // --- four back-to-back frames, gap-free output -----------------
        out_cnt = 0;
        base = acc_cnt;
        k = 0;
        while (acc_cnt - base < 4 * N && k < 100) begin
            tick(1'b1, 1'b1, DW'($urandom), DW'($urandom), 1'b1);
            k++;
        end
        chk("b2b_accept_cycles", 64'(k), 64'd32);
        drain(1'b0);
        chk("b2b_out_count", 64'(out_cnt), 64'd32);
        chk("b2b_gap_free", 64'(last_out - first_out + 1), 64'd32);

        // --- out_ready toggling every cycle ----------------------------
        out_cnt = 0;
        base = acc_cnt;
        k = 0;
        while (acc_cnt - base < 2 * N && k < 100) begin
            tick(1'b1, 1'b1, DW'($urandom), DW'($urandom), 1'(cyc));
            k++;
        end
        drain(1'b1);
        chk("tog_out_count", 64'(out_cnt), 64'd16);

        // --- reset in the middle of a frame ----------------------------
        for (int i = 0; i < N; i++) tick(1'b1, 1'b1, DW'(500 + i), DW'(600 + i), 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, DW'(700 + i), DW'(800 + i), 1'b0);
        apply_reset();
        out_cnt = 0;
        for (int i = 0; i < N; i++) tick(1'b1, 1'b1, DW'(40 + i), DW'(50 + i), 1'b1);
        drain(1'b0);
        chk("rst_fresh_count", 64'(out_cnt), 64'd8);

        // --- randomized traffic against the frame model ----------------
        for (int i = 0; i < 600; i++)
            tick(($urandom % 3) != 0, 1'b1, DW'($urandom), DW'($urandom), ($urandom % 4) != 0);
        drain(1'b0);
        chk("rand_no_ovf", 64'(overflow), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
